// File: rtl/divisor_pkg.sv
// Shared definitions for the signed restoring divider.
// Holds the FSM state encoding, the operand width, the iteration count and
// a magnitude helper used when latching operands.
package divisor_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int ITER_COUNT  = 32;
    localparam int CNT_W       = $clog2(ITER_COUNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Unsigned magnitude of a two's-complement value. The result is read as
    // unsigned, so |0x80000000| comes out exactly as 0x80000000.
    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] x);
        magnitude = x[DIV_WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/divisor_passo.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem_in   - current 33-bit partial remainder
//   quo_in   - current quotient/dividend shift register
//   div_in   - 33-bit divisor magnitude
//   rem_out  - partial remainder after this step
//   quo_out  - quotient register after this step (new bit in bit 0)
module divisor_passo
    import divisor_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH:0]   div_in,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             keep;

    // One extra bit above the remainder lets the trial difference carry a
    // reliable sign regardless of operand magnitude.
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign trial   = shifted - {1'b0, div_in};
    assign keep    = ~trial[WIDTH+1];

    assign rem_out = keep ? trial[WIDTH:0] : shifted[WIDTH:0];
    assign quo_out = {quo_in[WIDTH-2:0], keep};

endmodule

// File: rtl/divisor.sv
// Signed 32-bit sequential divider (restoring algorithm, 32 iterations).
// Quotient truncates toward zero, remainder follows the dividend's sign.
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-low reset
//   div_start  - start request; operands sampled on the same edge
//   outA/outB  - signed dividend / divisor
//   hi/lo      - registered remainder / quotient
//   ciclos_end - one-cycle completion pulse
//   div_zero   - sticky divide-by-zero flag, cleared by the next valid start
module divisor
    import divisor_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] outA,
    input  logic [WIDTH-1:0] outB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ciclos_end,
    output logic             div_zero
);

    state_t           state_reg, state_next;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH:0]   divisor_reg;
    logic             sign_a_reg, sign_b_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             ciclos_end_reg, div_zero_reg;

    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             b_is_zero;
    logic             load_en, zero_en, step_en, fix_en;

    assign b_is_zero = (outB == '0);

    divisor_passo #(.WIDTH(WIDTH)) u_passo (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .div_in  (divisor_reg),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: any start wins over the current operation.
    always_comb begin
        state_next = state_reg;
        if (div_start) begin
            state_next = b_is_zero ? ST_IDLE : ST_CALC;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_IDLE;
                // Leave CALC on the edge that brings the counter to zero.
                ST_CALC: if (cnt_reg == CNT_W'(1)) state_next = ST_FIX;
                ST_FIX:  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output/control decode
    always_comb begin
        load_en = 1'b0;
        zero_en = 1'b0;
        step_en = 1'b0;
        fix_en  = 1'b0;
        if (div_start) begin
            if (b_is_zero) zero_en = 1'b1;
            else           load_en = 1'b1;
        end else begin
            case (state_reg)
                ST_CALC: step_en = 1'b1;
                ST_FIX:  fix_en  = 1'b1;
                default: ;
            endcase
        end
    end

    // Datapath
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_reg        <= '0;
            quo_reg        <= '0;
            divisor_reg    <= '0;
            sign_a_reg     <= 1'b0;
            sign_b_reg     <= 1'b0;
            cnt_reg        <= '0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            ciclos_end_reg <= 1'b0;
            div_zero_reg   <= 1'b0;
        end else begin
            ciclos_end_reg <= 1'b0;
            if (load_en) begin
                // The dividend magnitude seeds the quotient register and is
                // shifted out MSB-first into the remainder.
                divisor_reg  <= {1'b0, magnitude(outB)};
                quo_reg      <= magnitude(outA);
                rem_reg      <= '0;
                sign_a_reg   <= outA[WIDTH-1];
                sign_b_reg   <= outB[WIDTH-1];
                cnt_reg      <= CNT_W'(ITER_COUNT);
                div_zero_reg <= 1'b0;
            end else if (zero_en) begin
                div_zero_reg   <= 1'b1;
                ciclos_end_reg <= 1'b1;
            end else if (step_en) begin
                rem_reg <= rem_step;
                quo_reg <= quo_step;
                cnt_reg <= cnt_reg - CNT_W'(1);
            end else if (fix_en) begin
                // 0x80000000 / -1 wraps naturally to 0x80000000 here.
                lo_reg         <= (sign_a_reg ^ sign_b_reg) ? (~quo_reg + 1'b1) : quo_reg;
                hi_reg         <= sign_a_reg ? (~rem_reg[WIDTH-1:0] + 1'b1) : rem_reg[WIDTH-1:0];
                ciclos_end_reg <= 1'b1;
            end
        end
    end

    assign hi         = hi_reg;
    assign lo         = lo_reg;
    assign ciclos_end = ciclos_end_reg;
    assign div_zero   = div_zero_reg;

endmodule

// File: doc/divisor.md
DIVISOR -- requirements
Module: divisor

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width; only 32 is supported and verified.
REQ-002 clock  input  1  rising-edge clock; the block's only clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 div_start  input  1  start request, sampled on each rising edge.
REQ-005 outA  input  32  dividend, signed two's complement; sampled only on the start edge.
REQ-006 outB  input  32  divisor, signed two's complement; sampled only on the start edge.
REQ-007 hi  output  32  remainder, registered.
REQ-008 lo  output  32  quotient, registered.
REQ-009 ciclos_end  output  1  one-cycle completion pulse, registered.
REQ-010 div_zero  output  1  divide-by-zero flag, registered.

Function
REQ-011 The block SHALL compute signed division: quotient truncated toward zero; remainder takes the sign of the dividend; A = lo*B + hi.
REQ-012 The FSM SHALL have states IDLE, CALC and FIX, and SHALL leave reset in IDLE.
REQ-013 Start edge E0, div_start=1 and outB!=0:
- latch |outA| and |outB| plus both operand signs;
- clear the 33-bit partial remainder;
- load the iteration counter with 32;
- clear div_zero and ciclos_end;
- go to CALC.
REQ-014 In CALC, each edge E1..E32 SHALL perform one restoring step:
- shift {remainder, quotient} left by 1;
- trial-subtract |B| from the 33-bit remainder;
- if the result is non-negative, keep it and set quotient bit 0 to 1; otherwise restore the remainder and set quotient bit 0 to 0;
- decrement the counter.
REQ-015 After the edge that decrements the counter to 0 (E32), the FSM SHALL go to FIX.
REQ-016 At E33 (FIX), the block SHALL:
- negate the quotient if the operand signs differ;
- negate the remainder if the dividend is negative;
- register the results into lo and hi;
- set ciclos_end=1;
- return to IDLE.
REQ-017 ciclos_end SHALL be high for exactly one cycle, between E33 and E34, and low at every other time.
REQ-018 hi and lo SHALL hold their last results until the next FIX or reset, and SHALL NOT change during CALC.
REQ-019 Start edge E0 with outB==0:
- set div_zero=1 and ciclos_end=1 at E0;
- leave hi and lo unchanged;
- stay in IDLE;
- ciclos_end falls at E1; div_zero holds until the next accepted div_start.
REQ-020 Overflow, outA=0x80000000 and outB=0xFFFFFFFF: the block SHALL give lo=0x80000000 and hi=0, with div_zero=0 and no extra flag.
REQ-021 A div_start in CALC or FIX SHALL abort the current operation and restart per REQ-013/REQ-019 with the new operands; the aborted operation SHALL produce no ciclos_end.
REQ-022 If div_start is held high, the block SHALL restart on every edge and SHALL NOT complete.
REQ-023 Internal magnitude arithmetic SHALL be 33 bits wide, so that |0x80000000| is represented exactly.

Reset
REQ-024 While reset=0, the following SHALL be cleared asynchronously and held at 0: hi, lo, ciclos_end, div_zero, the counter and all internal registers; state SHALL be IDLE.
REQ-025 Reset asserted mid-operation SHALL abandon the operation with no ciclos_end pulse afterwards.
REQ-026 After reset deasserts, the block SHALL be idle until the first div_start edge.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE, CALC, FIX), WIDTH, and the iteration-count constant (32).
REQ-028 The single restoring iteration SHALL be a combinational sub-module named divisor_passo (inputs: remainder, quotient, |B|; outputs: next remainder, next quotient).
REQ-029 The block SHALL NOT use behavioural "/" or "%" operators.

Verification
REQ-030 outA=100, outB=7, div_start at E0 -> lo=14, hi=2, ciclos_end high only between E33 and E34.
REQ-031 outA=-7 (0xFFFFFFF9), outB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; outA=7, outB=-2 -> lo=0xFFFFFFFD, hi=1.
REQ-032 outA=5, outB=0 after a previous result of 14/2 -> div_zero=1 and ciclos_end=1 right after E0, hi=2 and lo=14 unchanged; next valid start clears div_zero.
REQ-033 outA=0x80000000, outB=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0 at E33.
REQ-034 Start 100/7 at E0, then reset low between E10 and E11 -> all outputs 0 immediately; no ciclos_end within 40 cycles after release.
REQ-035 Start 100/7 at E0, restart with 9/4 at E5 -> single ciclos_end at E38 with lo=2, hi=1; no pulse at E33.
